// File: rtl/sdram_wr_burst_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_wr_burst_fifo_if
// Description : Handshake/data bundle between the SDRAM write-burst FIFO and
//               its user. "master" drives writes, reads and flush. "slave" is
//               the FIFO side. Optional macro: FIFO_PEAK_EN adds peak_usedw.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_wr_burst_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    logic                  flush;
    logic [DATA_WIDTH-1:0] di;
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    logic                  empty_flag;
    logic                  aempty;
    logic                  full_flag;
    logic                  afull;
    logic                  wr_success;
    logic                  overflow;
    logic                  underflow;
    logic [ADDR_WIDTH:0]   usedw;
    logic                  burst_rdy;
`ifdef FIFO_PEAK_EN
    logic [ADDR_WIDTH:0]   peak_usedw;

    modport master (
        output flush, di, we, re,
        input  dout, valid, empty_flag, aempty, full_flag, afull,
               wr_success, overflow, underflow, usedw, burst_rdy, peak_usedw
    );

    modport slave (
        input  flush, di, we, re,
        output dout, valid, empty_flag, aempty, full_flag, afull,
               wr_success, overflow, underflow, usedw, burst_rdy, peak_usedw
    );
`else
    modport master (
        output flush, di, we, re,
        input  dout, valid, empty_flag, aempty, full_flag, afull,
               wr_success, overflow, underflow, usedw, burst_rdy
    );

    modport slave (
        input  flush, di, we, re,
        output dout, valid, empty_flag, aempty, full_flag, afull,
               wr_success, overflow, underflow, usedw, burst_rdy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/sdram_wr_burst_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sdram_wr_burst_fifo
// Description : Single-clock show-ahead FIFO that buffers write data ahead of
//               the SDRAM controller. It provides burst-ready indication,
//               almost-full/almost-empty thresholds, and synchronous flush.
//               Optional macro: FIFO_PEAK_EN adds a peak_usedw
//               high-water-mark output.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_wr_burst_fifo #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 9,
    parameter int                    BURST_LEN    = 256,
    parameter int                    AL_FULL_NUM  = 509,
    parameter int                    AL_EMPTY_NUM = 2,
    parameter logic [DATA_WIDTH-1:0] DOUT_INITVAL = '0
) (
    input wire clk,
    input wire rst,
    sdram_wr_burst_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] c_DEPTH    = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_BURST    = BURST_LEN[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_AL_FULL  = AL_FULL_NUM[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_AL_EMPTY = AL_EMPTY_NUM[ADDR_WIDTH:0];

    // Storage is deliberately left without reset, so it can map onto RAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   usedw_q;
    logic [ADDR_WIDTH:0]   usedw_d;
    logic                  empty_q;
    logic                  aempty_q;
    logic                  full_q;
    logic                  afull_q;
    logic                  burst_rdy_q;
    logic                  wr_success_q;
    logic                  overflow_q;
    logic                  underflow_q;

    // Acceptance is decided from the flags before the edge. Empty and full
    // are exclusive, so a simultaneous request degrades to one side only.
    logic w_wr_acc;
    logic w_rd_acc;
    assign w_wr_acc = bus.we && !full_q  && !bus.flush;
    assign w_rd_acc = bus.re && !empty_q && !bus.flush;

    // Compute the occupancy for the next cycle. Flush forces it to zero.
    always_comb begin
        usedw_d = usedw_q;
        if (bus.flush) begin
            usedw_d = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            usedw_d = usedw_q + 1'b1;
        end else if (w_rd_acc && !w_wr_acc) begin
            usedw_d = usedw_q - 1'b1;
        end
    end

    // Write port for the storage array
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[wr_ptr_q] <= bus.di;
        end
    end

    // Pointers, occupancy, flags and event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            usedw_q      <= '0;
            empty_q      <= 1'b1;
            aempty_q     <= 1'b1;
            full_q       <= 1'b0;
            afull_q      <= 1'b0;
            burst_rdy_q  <= 1'b0;
            wr_success_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (w_wr_acc) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (w_rd_acc) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
            usedw_q      <= usedw_d;
            empty_q      <= (usedw_d == '0);
            aempty_q     <= (usedw_d <= c_AL_EMPTY);
            full_q       <= (usedw_d == c_DEPTH);
            afull_q      <= (usedw_d >= c_AL_FULL);
            burst_rdy_q  <= (usedw_d >= c_BURST);
            wr_success_q <= w_wr_acc;
            overflow_q   <= bus.we && full_q  && !bus.flush;
            underflow_q  <= bus.re && empty_q && !bus.flush;
        end
    end

    // The head word is shown combinationally from the read pointer.
    // It reads as the init value whenever nothing is stored.
    assign bus.dout       = empty_q ? DOUT_INITVAL : mem_q[rd_ptr_q];
    assign bus.valid      = !empty_q;
    assign bus.empty_flag = empty_q;
    assign bus.aempty     = aempty_q;
    assign bus.full_flag  = full_q;
    assign bus.afull      = afull_q;
    assign bus.burst_rdy  = burst_rdy_q;
    assign bus.usedw      = usedw_q;
    assign bus.wr_success = wr_success_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;

`ifdef FIFO_PEAK_EN
    logic [ADDR_WIDTH:0] peak_q;

    // High-water mark of the registered occupancy, lagging it by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else if (bus.flush) begin
            peak_q <= '0;
        end else if (usedw_q > peak_q) begin
            peak_q <= usedw_q;
        end
    end

    assign bus.peak_usedw = peak_q;
`endif

endmodule
`default_nettype wire

// File: doc/sdram_wr_burst_fifo.md
Name: sdram_wr_burst_fifo

Overview:
- Single-clock, parametrised show-ahead FIFO that buffers write data ahead of the SDRAM controller.
- Generalises the fixed 16x512 dual-clock write FIFO in data width, depth and thresholds.
- Adds a burst-ready indication so the controller issues a full write burst only once BURST_LEN words are buffered.
- Adds a synchronous flush.

Parameters:
DATA_WIDTH, 16, word width
ADDR_WIDTH, 9, log2 depth; DEPTH = 2**ADDR_WIDTH
BURST_LEN, 256, words per SDRAM write burst; 1..DEPTH
AL_FULL_NUM, 509, afull asserts when usedw >= AL_FULL_NUM
AL_EMPTY_NUM, 2, aempty asserts when usedw <= AL_EMPTY_NUM
DOUT_INITVAL, 0, dout value while FIFO empty

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of contents and sticky state
di  in  DATA_WIDTH  write data
we  in  1  write request
re  in  1  read request (acknowledges current dout)
dout  out  DATA_WIDTH  show-ahead head word
valid  out  1  dout holds a real word (= !empty_flag)
empty_flag  out  1  FIFO empty
aempty  out  1  almost empty
full_flag  out  1  FIFO full
afull  out  1  almost full
wr_success  out  1  write accepted this cycle (registered pulse)
overflow  out  1  write rejected because full (registered pulse)
underflow  out  1  read rejected because empty (registered pulse)
usedw  out  ADDR_WIDTH+1  words stored, 0..DEPTH
burst_rdy  out  1  usedw >= BURST_LEN

Behaviour:
- Reset (async assert, released on clk): pointers/usedw = 0; empty_flag = 1, aempty = 1; full_flag, afull, burst_rdy, wr_success, overflow, underflow, valid = 0; dout = DOUT_INITVAL.
- flush: same values as reset, applied at the next clk edge. Overrides we/re in that cycle; no pulses are generated.
- Write accepted iff we && !full_flag, judged on pre-edge state. Store di at wr_ptr; wr_ptr wraps modulo DEPTH.
- Read accepted iff re && !empty_flag. rd_ptr increments and wraps modulo DEPTH.
- usedw: +1 on write only, -1 on read only, unchanged on simultaneous accepted read+write.
- Full + we + re: read accepted, write rejected, overflow pulses, usedw = DEPTH-1.
- Empty + we + re: write accepted, read rejected, underflow pulses, usedw = 1.
- Flags derive from the registered usedw:
  - empty_flag = (usedw==0), full_flag = (usedw==DEPTH)
  - afull, aempty, burst_rdy per parameter thresholds
  - all update in the cycle after the causing edge
- Show-ahead: dout = storage[rd_ptr] when valid, else DOUT_INITVAL.
  - First word is visible the cycle after the write edge (latency 1).
  - After an accepted read, the next word appears the cycle after the read edge.
- Back-to-back reads at one per clock are legal while usedw > 0.
- Pulse timing: wr_success/overflow/underflow are 1-cycle pulses, asserted in the cycle after the request edge, and cleared when no event occurs.
- Storage has no reset; only pointers and flags reset.

Optional Feature:
- Macro FIFO_PEAK_EN.
- Defined:
  - Extra output peak_usedw (ADDR_WIDTH+1) holds the maximum usedw seen since reset/flush.
  - Updated one cycle after usedw; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, write 3 words 0x0001..0x0003 with no reads -> wr_success 3 pulses; dout = 0x0001 one cycle after first write; usedw = 3, aempty = 0 after third.
- Fill DEPTH=512 words, then we once more -> full_flag = 1, afull from usedw = 509; extra write gives overflow pulse, usedw stays 512.
- Fill 512, assert we+re together -> usedw = 511, overflow = 1, dout advances to word 2.
- Empty FIFO, re alone -> underflow pulse, dout = DOUT_INITVAL; empty + we + re -> usedw = 1, underflow = 1.
- BURST_LEN=256: write 255 -> burst_rdy = 0; 256th write -> burst_rdy = 1 next cycle; drain 1 -> burst_rdy = 0.
- Write 10 then flush mid-stream with we=1 -> usedw = 0, empty_flag = 1, no wr_success; with FIFO_PEAK_EN peak_usedw = 10 before flush, 0 after. Then 600 write/read pairs to verify pointer wrap and data order.
